// File: rtl/hit_mon_pkg.sv
// hit_mon_pkg: state type, default parameters and saturating add shared by ones_hit_monitor.
package hit_mon_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_WIN_LEN = 16;
    localparam int unsigned DEF_THRESH  = 3;
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: accumulator that adds inc when en is high, clamps at all-ones, clr has priority.
module sat_counter
    import hit_mon_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= W'(sat_add(32'(q), 32'(inc), W));
    end
endmodule

// File: rtl/ones_hit_monitor.sv
// ones_hit_monitor: counts detector hits per WIN_LEN-cycle window, latches count and alarm at close.
// Define HIT_MON_TOTAL_EN to build the saturating running total; otherwise total is tied to 0.
module ones_hit_monitor
    import hit_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned WIN_LEN = DEF_WIN_LEN,
    parameter int unsigned THRESH  = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             z_in,
    output logic [CNT_W-1:0] win_count,
    output logic             win_valid,
    output logic             alarm,
    output logic [CNT_W-1:0] total
);
    localparam int unsigned CW = $clog2(WIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);
    state_e state;
    logic [CW-1:0] cyc_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] win_val;
    logic close;
    // clr beats a coincident close; a window can only close once RUN has been entered
    assign close = en && !clr && state == RUN && cyc_cnt == LAST;
    assign win_val = CNT_W'(sat_add(32'(hit_cnt), 32'(z_in), CNT_W));
    sat_counter #(.W(CNT_W)) u_hit (
        .clk(clk), .rst(rst), .en(1'b1), .clr(!en || clr || close),
        .inc(CNT_W'(z_in)), .q(hit_cnt)
    );
`ifdef HIT_MON_TOTAL_EN
    sat_counter #(.W(CNT_W)) u_total (
        .clk(clk), .rst(rst), .en(close), .clr(clr), .inc(win_val), .q(total)
    );
`else
    assign total = '0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            win_count <= '0;
            win_valid <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= en ? RUN : IDLE;
            cyc_cnt   <= (!en || clr || close) ? '0 : cyc_cnt + 1'b1;
            win_valid <= close;
            if (close) begin
                win_count <= win_val;
                alarm     <= 32'(win_val) >= THRESH;
            end
        end
    end
endmodule
